// File: rtl/ex_madd_unit_if.sv
// Handshake/operand bundle between the EX stage and the multi-cycle MADD engine.
// Signal names match the original flat port list of ex_madd_unit.
interface ex_madd_unit_if #(
   parameter int unsigned OPW = 32
);
   logic               start_i;
   logic               signed_i;
   logic               sub_i;
   logic [OPW-1:0]     opdata1_i;
   logic [OPW-1:0]     opdata2_i;
   logic [OPW-1:0]     hi_i;
   logic [OPW-1:0]     lo_i;
   logic               annul_i;
   logic               hold_i;
   logic               stallreq_o;
   logic               ready_o;
   logic [2*OPW-1:0]   result_o;

   modport master (
      output start_i, signed_i, sub_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i, hold_i,
      input  stallreq_o, ready_o, result_o
   );

   modport slave (
      input  start_i, signed_i, sub_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i, hold_i,
      output stallreq_o, ready_o, result_o
   );
endinterface

// File: rtl/ex_madd_unit.sv
// Multi-cycle MADD/MADDU/MSUB/MSUBU engine: shift-add multiply over OPW cycles,
// then one accumulate cycle into the 64-bit {HI,LO} value latched at acceptance.
module ex_madd_unit #(
   parameter int unsigned OPW = 32
) (
   input  logic               clk,
   input  logic               rst,
   ex_madd_unit_if.slave      bus
);
   localparam int unsigned W  = 2 * OPW;
   localparam int unsigned CW = $clog2(OPW);
   localparam logic [CW-1:0] CNT_LAST = CW'(OPW - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [OPW-1:0]  r_mcand;
   logic [OPW-1:0]  r_mplier;
   logic [W-1:0]    r_prod;
   logic [W-1:0]    r_acc;
   logic            r_neg;
   logic            r_sub;
   logic [W-1:0]    r_result;
   logic            r_ready;

   logic [OPW-1:0]  w_mag1;
   logic [OPW-1:0]  w_mag2;
   logic            w_neg;
   logic [W-1:0]    w_term;
   logic [W-1:0]    w_p;
   logic [W-1:0]    w_acc_next;

   always_comb begin
      w_mag1 = (bus.signed_i && bus.opdata1_i[OPW-1]) ? (~bus.opdata1_i + OPW'(1)) : bus.opdata1_i;
      w_mag2 = (bus.signed_i && bus.opdata2_i[OPW-1]) ? (~bus.opdata2_i + OPW'(1)) : bus.opdata2_i;
      w_neg  = bus.signed_i & (bus.opdata1_i[OPW-1] ^ bus.opdata2_i[OPW-1]);
      w_term = r_mplier[r_cnt] ? ({{OPW{1'b0}}, r_mcand} << r_cnt) : '0;
      w_p    = r_neg ? (~r_prod + W'(1)) : r_prod;
      w_acc_next = r_sub ? (r_acc - w_p) : (r_acc + w_p);
   end

   // Annul masks the request in the same cycle so the controller never sees a stall it then drops.
   assign bus.stallreq_o = ~bus.annul_i &
                           (((r_state == S_IDLE) & bus.start_i) |
                            (r_state == S_MUL) | (r_state == S_ACC));
   assign bus.ready_o    = r_ready;
   assign bus.result_o   = r_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_sub    <= 1'b0;
         r_result <= '0;
         r_ready  <= 1'b0;
      end else if (bus.annul_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start_i) begin
                  r_mcand  <= w_mag1;
                  r_mplier <= w_mag2;
                  r_neg    <= w_neg;
                  r_acc    <= {bus.hi_i, bus.lo_i};
                  r_sub    <= bus.sub_i;
                  r_prod   <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_MUL;
               end
            end
            S_MUL: begin
               r_prod <= r_prod + w_term;
               r_cnt  <= r_cnt + CW'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_ACC;
               end
            end
            S_ACC: begin
               r_result <= w_acc_next;
               r_ready  <= 1'b1;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               if (!bus.hold_i) begin
                  r_ready <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_madd_unit.sv
// Self-checking bench for ex_madd_unit: directed cases, randomized ops against an
// arithmetic reference, annul/reset aborts and hold/back-to-back behaviour.
module tb_ex_madd_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_madd_unit_if #(.OPW(32)) bus ();
   ex_madd_unit #(.OPW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;
   logic [63:0] exp_result;

   function automatic logic [63:0] ref_madd(input bit sgn, input bit sub,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] acc);
      longint sa, sb;
      logic [63:0] p;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         p  = 64'(sa * sb);
      end else begin
         p = {32'b0, a} * {32'b0, b};
      end
      return sub ? (acc - p) : (acc + p);
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] corner [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
      return $urandom;
   endfunction

   task automatic idle_inputs();
      bus.start_i = 0; bus.signed_i = 0; bus.sub_i = 0;
      bus.opdata1_i = '0; bus.opdata2_i = '0; bus.hi_i = '0; bus.lo_i = '0;
      bus.annul_i = 0; bus.hold_i = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one operation from an IDLE cycle and records what the DUT shows; no checks here.
   task automatic do_op(input bit sgn, input bit sub, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] acc, output int stall_cnt, output int ready_cnt,
                        output logic ready34, output logic stall34, output logic [63:0] res34);
      bus.start_i = 1; bus.signed_i = sgn; bus.sub_i = sub;
      bus.opdata1_i = a; bus.opdata2_i = b; bus.hi_i = acc[63:32]; bus.lo_i = acc[31:0];
      #1;
      stall_cnt = int'(bus.stallreq_o);
      ready_cnt = int'(bus.ready_o);
      for (int c = 1; c <= 33; c++) begin
         step();
         if (c == 1) begin
            bus.start_i = 0; bus.signed_i = $urandom_range(1); bus.sub_i = $urandom_range(1);
            bus.opdata1_i = $urandom; bus.opdata2_i = $urandom;
            bus.hi_i = $urandom; bus.lo_i = $urandom;
            #1;
         end
         stall_cnt += int'(bus.stallreq_o);
         ready_cnt += int'(bus.ready_o);
      end
      step();
      ready34 = bus.ready_o;
      stall34 = bus.stallreq_o;
      res34   = bus.result_o;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.ready_o !== 1'b0) $display("FAIL reset_ready got=%b want=0", bus.ready_o); else n_pass++;
      n_checks++; if (bus.result_o !== 64'h0) $display("FAIL reset_result got=%h want=0", bus.result_o); else n_pass++;
      n_checks++; if (bus.stallreq_o !== 1'b0) $display("FAIL reset_stallreq got=%b want=0", bus.stallreq_o); else n_pass++;
      rst = 0;
      exp_result = '0;
   endtask

   task automatic test_directed();
      bit          sg_t [6] = '{0, 1, 1, 0, 0, 0};
      bit          sb_t [6] = '{0, 0, 1, 0, 0, 1};
      logic [31:0] a_t  [6] = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd1};
      logic [31:0] b_t  [6] = '{32'd4, 32'd2, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd1};
      logic [63:0] ac_t [6] = '{64'h5, 64'hA, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      logic [63:0] ex_t [6] = '{64'h11, 64'h8, 64'hC000_0000_0000_0000, 64'h4000_0000_0000_0000,
                                64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      int sc, rc; logic r34, s34; logic [63:0] res;
      for (int i = 0; i < 6; i++) begin
         step();
         do_op(sg_t[i], sb_t[i], a_t[i], b_t[i], ac_t[i], sc, rc, r34, s34, res);
         n_checks++; if (sc != 34) $display("FAIL dir%0d_stall_cycles got=%0d want=34", i, sc); else n_pass++;
         n_checks++; if (rc != 0) $display("FAIL dir%0d_early_ready got=%0d want=0", i, rc); else n_pass++;
         n_checks++; if (r34 !== 1'b1) $display("FAIL dir%0d_ready34 got=%b want=1", i, r34); else n_pass++;
         n_checks++; if (s34 !== 1'b0) $display("FAIL dir%0d_stall34 got=%b want=0", i, s34); else n_pass++;
         n_checks++; if (res !== ex_t[i]) $display("FAIL dir%0d_result got=%h want=%h", i, res, ex_t[i]); else n_pass++;
         exp_result = ex_t[i];
      end
   endtask

   task automatic test_random();
      int sc, rc; logic r34, s34; logic [63:0] res, acc, exp;
      bit sg, sb; logic [31:0] a, b;
      for (int i = 0; i < 10; i++) begin
         sg = $urandom_range(1); sb = $urandom_range(1);
         a = pick_operand(); b = pick_operand();
         acc = {pick_operand(), pick_operand()};
         exp = ref_madd(sg, sb, a, b, acc);
         step();
         do_op(sg, sb, a, b, acc, sc, rc, r34, s34, res);
         n_checks++; if (sc != 34 || rc != 0) $display("FAIL rnd%0d_timing stall=%0d ready_early=%0d want 34/0", i, sc, rc); else n_pass++;
         n_checks++; if (r34 !== 1'b1) $display("FAIL rnd%0d_ready got=%b want=1", i, r34); else n_pass++;
         n_checks++; if (res !== exp) $display("FAIL rnd%0d_result s=%0d sub=%0d a=%h b=%h acc=%h got=%h want=%h", i, sg, sb, a, b, acc, res, exp); else n_pass++;
         exp_result = exp;
      end
   endtask

   task automatic test_annul();
      int sc, rc; logic r34, s34; logic [63:0] res;
      step();
      bus.start_i = 1; bus.annul_i = 1; bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd9;
      #1;
      n_checks++; if (bus.stallreq_o !== 1'b0) $display("FAIL annul_start_stall got=%b want=0", bus.stallreq_o); else n_pass++;
      step();
      bus.start_i = 0; bus.annul_i = 0;
      #1;
      n_checks++; if (bus.stallreq_o !== 1'b0) $display("FAIL annul_start_nostart got=%b want=0", bus.stallreq_o); else n_pass++;
      bus.start_i = 1; bus.signed_i = 0; bus.sub_i = 0; bus.opdata1_i = 32'd5; bus.opdata2_i = 32'd7;
      bus.hi_i = '0; bus.lo_i = '0;
      step();
      bus.start_i = 0;
      repeat (10) @(posedge clk);
      #1;
      bus.annul_i = 1;
      #1;
      n_checks++; if (bus.stallreq_o !== 1'b0) $display("FAIL annul_mul_stall got=%b want=0", bus.stallreq_o); else n_pass++;
      step();
      bus.annul_i = 0;
      #1;
      n_checks++; if (bus.stallreq_o !== 1'b0) $display("FAIL annul_after_stall got=%b want=0", bus.stallreq_o); else n_pass++;
      n_checks++; if (bus.ready_o !== 1'b0) $display("FAIL annul_after_ready got=%b want=0", bus.ready_o); else n_pass++;
      n_checks++; if (bus.result_o !== exp_result) $display("FAIL annul_after_result got=%h want=%h", bus.result_o, exp_result); else n_pass++;
      do_op(0, 0, 32'd2, 32'd3, 64'h0, sc, rc, r34, s34, res);
      n_checks++; if (sc != 34 || r34 !== 1'b1) $display("FAIL annul_restart_timing stall=%0d ready=%b want 34/1", sc, r34); else n_pass++;
      n_checks++; if (res !== 64'd6) $display("FAIL annul_restart_result got=%h want=6", res); else n_pass++;
      exp_result = 64'd6;
   endtask

   task automatic test_rst_mid();
      step();
      bus.start_i = 1; bus.signed_i = 1; bus.sub_i = 0;
      bus.opdata1_i = 32'h1234_5678; bus.opdata2_i = 32'h0000_0100; bus.hi_i = '0; bus.lo_i = '0;
      step();
      bus.start_i = 0;
      repeat (14) @(posedge clk);
      #1;
      rst = 1;
      step();
      rst = 0;
      n_checks++; if (bus.result_o !== 64'h0) $display("FAIL rst_mid_result got=%h want=0", bus.result_o); else n_pass++;
      n_checks++; if (bus.ready_o !== 1'b0) $display("FAIL rst_mid_ready got=%b want=0", bus.ready_o); else n_pass++;
      n_checks++; if (bus.stallreq_o !== 1'b0) $display("FAIL rst_mid_stall got=%b want=0", bus.stallreq_o); else n_pass++;
      exp_result = '0;
   endtask

   task automatic test_back_to_back();
      int sc, rc; logic r34, s34; logic [63:0] res, exp;
      step();
      exp = ref_madd(1, 0, 32'hFFFF_FFF9, 32'd3, 64'h0000_0001_0000_0000);
      do_op(1, 0, 32'hFFFF_FFF9, 32'd3, 64'h0000_0001_0000_0000, sc, rc, r34, s34, res);
      n_checks++; if (res !== exp || r34 !== 1'b1) $display("FAIL hold_first_result got=%h/%b want=%h/1", res, r34, exp); else n_pass++;
      exp_result = exp;
      bus.hold_i = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (bus.ready_o !== 1'b1 || bus.result_o !== exp_result)
            $display("FAIL hold%0d_stable got=%h/%b want=%h/1", i, bus.result_o, bus.ready_o, exp_result); else n_pass++;
      end
      bus.hold_i = 0;
      bus.start_i = 1; bus.signed_i = 0; bus.sub_i = 1;
      bus.opdata1_i = 32'd10; bus.opdata2_i = 32'd10; bus.hi_i = '0; bus.lo_i = 32'd150;
      #1;
      n_checks++; if (bus.stallreq_o !== 1'b0) $display("FAIL hold_done_stall got=%b want=0", bus.stallreq_o); else n_pass++;
      step();
      n_checks++; if (bus.ready_o !== 1'b0) $display("FAIL hold_release_ready got=%b want=0", bus.ready_o); else n_pass++;
      n_checks++; if (bus.stallreq_o !== 1'b1) $display("FAIL b2b_idle_stall got=%b want=1", bus.stallreq_o); else n_pass++;
      n_checks++; if (bus.result_o !== exp_result) $display("FAIL hold_release_result got=%h want=%h", bus.result_o, exp_result); else n_pass++;
      do_op(0, 1, 32'd10, 32'd10, 64'd150, sc, rc, r34, s34, res);
      n_checks++; if (sc != 34 || r34 !== 1'b1) $display("FAIL b2b_timing stall=%0d ready=%b want 34/1", sc, r34); else n_pass++;
      n_checks++; if (res !== 64'd50) $display("FAIL b2b_result got=%h want=32", res); else n_pass++;
      exp_result = 64'd50;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_annul();
      test_rst_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
